// File: rtl/spike_packet_encoder_if.sv
// rtl/spike_packet_encoder_if.sv - fire-event input and spike-packet output handshake bundle
interface spike_packet_encoder_if;
  logic        fire_valid;
  logic [6:0]  fire_id;
  logic        fire_rich;
  logic        fire_ready;
  logic        step_end;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] pkt_addr;
  logic        busy;
  logic [7:0]  drop_cnt;

  // Event source / packet sink side
  modport master (
    output fire_valid, fire_id, fire_rich, step_end, pkt_ready,
    input  fire_ready, pkt_valid, pkt_addr, busy, drop_cnt
  );

  // Encoder side
  modport slave (
    input  fire_valid, fire_id, fire_rich, step_end, pkt_ready,
    output fire_ready, pkt_valid, pkt_addr, busy, drop_cnt
  );
endinterface

// File: rtl/spike_packet_encoder.sv
// rtl/spike_packet_encoder.sv - buffers fire events and pairs non-rich spikes into 16-bit packets
module spike_packet_encoder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  spike_packet_encoder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
  localparam logic [6:0]    NULL_ID    = 7'h7F;

  typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [6:0]      hold_id_q, hold_id_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic [15:0]     pkt_addr_q, pkt_addr_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic            fire_ready;
  logic            handshake;
  logic            push;
  logic            drop_evt;
  logic            pop;
  logic            head_valid;
  logic [7:0]      head;
  logic            head_rich;
  logic [6:0]      head_id;

  // Ready is based on registered occupancy only, so a same-cycle pop never opens a slot early
  assign fire_ready = (count_q < DEPTH_C);
  assign handshake  = bus.fire_valid && fire_ready;
  assign push       = handshake && (bus.fire_id != NULL_ID);
  assign drop_evt   = handshake && (bus.fire_id == NULL_ID);

  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_rich  = head[7];
  assign head_id    = head[6:0];

  assign bus.fire_ready = fire_ready;
  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.pkt_addr   = pkt_addr_q;
  assign bus.busy       = head_valid || (state_q != IDLE);
  assign bus.drop_cnt   = drop_cnt_q;

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Saturating count of events discarded for carrying the NULL id
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Pairing FSM next state: rich spikes go out alone, non-rich spikes wait for a partner or a flush
  always_comb begin
    state_d     = state_q;
    hold_id_d   = hold_id_q;
    timer_d     = timer_q;
    pkt_valid_d = pkt_valid_q;
    pkt_addr_d  = pkt_addr_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_valid) begin
          pop = 1'b1;
          if (head_rich) begin
            pkt_addr_d  = {1'b0, 1'b1, head_id, NULL_ID};
            pkt_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            hold_id_d = head_id;
            timer_d   = '0;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (head_valid && !head_rich) begin
          // A waiting partner wins over a coincident step_end
          pop         = 1'b1;
          pkt_addr_d  = {1'b0, 1'b0, hold_id_q, head_id};
          pkt_valid_d = 1'b1;
          state_d     = SEND;
        end else if (head_valid) begin
          // Rich head stays queued; the held spike leaves unpaired
          pkt_addr_d  = {1'b0, 1'b0, hold_id_q, NULL_ID};
          pkt_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          timer_d = timer_q + 1'b1;
          if (bus.step_end || (timer_q == FLUSH_LAST)) begin
            pkt_addr_d  = {1'b0, 1'b0, hold_id_q, NULL_ID};
            pkt_valid_d = 1'b1;
            state_d     = SEND;
          end
        end
      end
      SEND: begin
        if (bus.pkt_ready) begin
          pkt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        pkt_valid_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents are only meaningful below the occupancy count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.fire_rich, bus.fire_id};
    end
  end

  // All control state and registered outputs, cleared asynchronously so pending events are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_id_q   <= '0;
      timer_q     <= '0;
      pkt_valid_q <= 1'b0;
      pkt_addr_q  <= 16'h0000;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_id_q   <= hold_id_d;
      timer_q     <= timer_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_addr_q  <= pkt_addr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_spike_packet_encoder.sv
// tb/tb_spike_packet_encoder.sv - randomized and directed checks of spike_packet_encoder against a queue model
module tb_spike_packet_encoder;

  localparam int DEPTH = 8;
  localparam int FLUSH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spike_packet_encoder_if bus ();

  spike_packet_encoder #(.FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {rich,id} words, one optional held id, one optional outgoing packet
  int          mq[$];
  int          held  = -1;
  int          timer = 0;
  bit          out_v = 1'b0;
  logic [15:0] out_a = 16'h0000;
  int          drops = 0;

  always @(posedge clk or negedge rst) begin : model
    int e;
    bit acc;
    if (!rst) begin
      mq.delete();
      held  = -1;
      timer = 0;
      out_v = 1'b0;
      out_a = 16'h0000;
      drops = 0;
    end else begin
      acc = bus.fire_valid && (mq.size() < DEPTH);
      if (out_v) begin
        if (bus.pkt_ready) out_v = 1'b0;
      end else if (held < 0) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e >= 128) begin
            out_v = 1'b1;
            out_a = {2'b01, 7'(e - 128), 7'h7F};
          end else begin
            held  = e;
            timer = 0;
          end
        end
      end else if (mq.size() > 0) begin
        e = mq[0];
        if (e < 128) begin
          e = mq.pop_front();
          out_a = {2'b00, 7'(held), 7'(e)};
        end else begin
          out_a = {2'b00, 7'(held), 7'h7F};
        end
        out_v = 1'b1;
        held  = -1;
      end else if (bus.step_end || timer == FLUSH - 1) begin
        out_a = {2'b00, 7'(held), 7'h7F};
        out_v = 1'b1;
        held  = -1;
      end else begin
        timer++;
      end
      if (acc) begin
        if (bus.fire_id == 7'h7F) begin
          if (drops < 255) drops++;
        end else begin
          mq.push_back(bus.fire_rich ? 128 + int'(bus.fire_id) : int'(bus.fire_id));
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("m_fire_ready", 32'(bus.fire_ready), 32'(mq.size() < DEPTH));
    chk("m_pkt_valid",  32'(bus.pkt_valid),  32'(out_v));
    chk("m_pkt_addr",   32'(bus.pkt_addr),   32'(out_a));
    chk("m_busy",       32'(bus.busy),       32'((mq.size() > 0) || (held >= 0) || out_v));
    chk("m_drop_cnt",   32'(bus.drop_cnt),   32'(drops));
  end

  task automatic idle_wait(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic send_evt(input logic [6:0] id, input logic rich);
    int n = 0;
    bus.fire_valid = 1'b1;
    bus.fire_id    = id;
    bus.fire_rich  = rich;
    while (bus.fire_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(bus.fire_ready), 32'd1);
    @(negedge clk);
    bus.fire_valid = 1'b0;
  endtask

  task automatic wait_pkt(output logic [15:0] a);
    int n = 0;
    while (bus.pkt_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_wait", 32'(bus.pkt_valid), 32'd1);
    a = bus.pkt_addr;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [15:0] a;
    int n;
    int vprob, rprob, sprob;
    bus.fire_valid = 1'b0;
    bus.fire_id    = 7'd0;
    bus.fire_rich  = 1'b0;
    bus.step_end   = 1'b0;
    bus.pkt_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    chk("rst_pkt_addr",  32'(bus.pkt_addr),  32'h0000);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);
    #2 rst = 1'b1;
    #1 chk("rst_fire_ready", 32'(bus.fire_ready), 32'd1);
    @(negedge clk);

    // Pairing: 5 then 9
    bus.fire_valid = 1'b1; bus.fire_id = 7'd5; bus.fire_rich = 1'b0;
    @(negedge clk); bus.fire_id = 7'd9;
    @(negedge clk); bus.fire_valid = 1'b0;
    wait_pkt(a);
    chk("pair_5_9", 32'(a), 32'h0289);
    idle_wait("idle_pair");

    // Rich event latency and stability under backpressure
    bus.pkt_ready = 1'b0;
    bus.fire_valid = 1'b1; bus.fire_id = 7'd3; bus.fire_rich = 1'b1;
    @(negedge clk); bus.fire_valid = 1'b0;
    chk("rich_not_yet", 32'(bus.pkt_valid), 32'd0);
    @(negedge clk);
    chk("rich_valid_k1", 32'(bus.pkt_valid), 32'd1);
    chk("rich_addr", 32'(bus.pkt_addr), 32'h41FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rich_hold_valid", 32'(bus.pkt_valid), 32'd1);
      chk("rich_hold_addr", 32'(bus.pkt_addr), 32'h41FF);
    end
    bus.pkt_ready = 1'b1;
    @(negedge clk);
    chk("rich_drop_valid", 32'(bus.pkt_valid), 32'd0);
    idle_wait("idle_rich");

    // Timer flush of a lone spike
    bus.fire_valid = 1'b1; bus.fire_id = 7'd10; bus.fire_rich = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) bus.fire_valid = 1'b0;
    end while (bus.pkt_valid !== 1'b1 && n < 60);
    chk("flush_delay", 32'(n), 32'(FLUSH + 2));
    chk("flush_addr", 32'(bus.pkt_addr), 32'h057F);
    @(negedge clk);
    idle_wait("idle_flush");

    // Early flush by step_end two cycles into HOLD
    bus.fire_valid = 1'b1; bus.fire_id = 7'd10; bus.fire_rich = 1'b0;
    @(negedge clk); bus.fire_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.step_end = 1'b1;
    @(negedge clk); bus.step_end = 1'b0;
    chk("step_valid", 32'(bus.pkt_valid), 32'd1);
    chk("step_addr", 32'(bus.pkt_addr), 32'h057F);
    @(negedge clk);
    idle_wait("idle_step");

    // Rich interrupts a held spike
    bus.fire_valid = 1'b1; bus.fire_id = 7'd4; bus.fire_rich = 1'b0;
    @(negedge clk); bus.fire_id = 7'd6; bus.fire_rich = 1'b1;
    @(negedge clk); bus.fire_valid = 1'b0;
    wait_pkt(a);
    chk("intr_first", 32'(a), 32'h027F);
    wait_pkt(a);
    chk("intr_second", 32'(a), 32'h437F);
    idle_wait("idle_intr");

    // Backpressure: one rich in SEND plus eight buffered
    bus.pkt_ready = 1'b0;
    send_evt(7'd40, 1'b1);
    for (int i = 41; i <= 48; i++) send_evt(7'(i), 1'b0);
    chk("bp_full_ready", 32'(bus.fire_ready), 32'd0);
    chk("bp_first_addr", 32'(bus.pkt_addr), 32'h547F);
    bus.fire_valid = 1'b1; bus.fire_id = 7'd49; bus.fire_rich = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(bus.fire_ready), 32'd0);
    end
    bus.pkt_ready = 1'b1;
    send_evt(7'd49, 1'b0);
    wait_pkt(a);
    chk("bp_second", 32'(a), 32'h14AA);
    idle_wait("idle_bp");

    // NULL-id drops saturate
    bus.fire_valid = 1'b1; bus.fire_id = 7'h7F;
    for (int i = 0; i < 300; i++) begin
      bus.fire_rich = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.fire_valid = 1'b0;
    @(negedge clk);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Reset while a packet is pending and events are queued
    bus.pkt_ready = 1'b0;
    send_evt(7'd1, 1'b1);
    send_evt(7'd2, 1'b0);
    send_evt(7'd3, 1'b0);
    chk("pre_rst_valid", 32'(bus.pkt_valid), 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.pkt_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),      32'd0);
    chk("mid_rst_drop",  32'(bus.drop_cnt),  32'd0);
    #2 rst = 1'b1;
    bus.pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 32'(bus.pkt_valid), 32'd0);

    // Randomized traffic in phases of varying density and backpressure
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin vprob = 50; rprob = 70; sprob = 5; end
        1:       begin vprob = 90; rprob = 40; sprob = 2; end
        2:       begin vprob = 70; rprob = 10; sprob = 3; end
        default: begin vprob = 3;  rprob = 90; sprob = 1; end
      endcase
      for (int c = 0; c < 600; c++) begin
        bus.fire_valid = ($urandom_range(0, 99) < vprob);
        bus.fire_id    = ($urandom_range(0, 15) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
        bus.fire_rich  = ($urandom_range(0, 3) == 0);
        bus.step_end   = ($urandom_range(0, 99) < sprob);
        bus.pkt_ready  = ($urandom_range(0, 99) < rprob);
        @(negedge clk);
      end
      if (ph == 2) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
      end
    end
    bus.fire_valid = 1'b0;
    bus.step_end   = 1'b0;
    bus.pkt_ready  = 1'b1;
    @(negedge clk);
    idle_wait("idle_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
